// File: rtl/dbg_cmd_master_if.sv
// Host byte link, debug-bus request channel and status flags of dbg_cmd_master.
// The master modport is the command master's view; slave is the host/debug-module side.
interface dbg_cmd_master_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        dbg_req_o;
  logic        dbg_we_o;
  logic [31:0] dbg_addr_o;
  logic [31:0] dbg_wdata_o;
  logic        dbg_ack_i;
  logic [31:0] dbg_rdata_i;
  logic        busy_o;
  logic        overrun_o;

  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i, dbg_ack_i, dbg_rdata_i,
    output tx_data_o, tx_valid_o, dbg_req_o, dbg_we_o, dbg_addr_o, dbg_wdata_o,
    output busy_o, overrun_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i, dbg_ack_i, dbg_rdata_i,
    input  tx_data_o, tx_valid_o, dbg_req_o, dbg_we_o, dbg_addr_o, dbg_wdata_o,
    input  busy_o, overrun_o
  );
endinterface

// File: rtl/dbg_cmd_master.sv
// Turns host read/write frames into one debug-bus request each, then answers A5 (+rdata) or EE.
// Request lasts from 1 cycle to TIMEOUT_CYCLES; rx has no backpressure (dropped bytes set overrun), tx holds until ready.
module dbg_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              rstn_i,
  dbg_cmd_master_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam int            TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ovr_q, ovr_d;

  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_hs;
  logic [1:0]    rsel;

  // RESP byte 0 is the status; bytes 1..4 are rdata LSB-first
  assign rsel  = 2'(cnt_q - 3'd1);
  assign tx_hs = tx_valid && bus.tx_ready_i;

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    if (state_q == S_RESP) begin
      tx_valid = 1'b1;
      tx_data  = (cnt_q == 3'd0) ? 8'hA5 : rdata_q[{rsel, 3'b000} +: 8];
    end else if (state_q == S_ERR) begin
      tx_valid = 1'b1;
      tx_data  = 8'hEE;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid_i) begin
          cnt_d = 3'd0;
          if (bus.rx_data_i == 8'h01) begin
            we_d    = 1'b0;
            state_d = S_ADDR;
          end else if (bus.rx_data_i == 8'h02) begin
            we_d    = 1'b1;
            state_d = S_ADDR;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ADDR: begin
        if (bus.rx_valid_i) begin
          addr_d[{cnt_q[1:0], 3'b000} +: 8] = bus.rx_data_i;
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            state_d = we_q ? S_WDATA : S_REQ;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_WDATA: begin
        if (bus.rx_valid_i) begin
          wdata_d[{cnt_q[1:0], 3'b000} +: 8] = bus.rx_data_i;
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            state_d = S_REQ;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_REQ: begin
        // ack wins over a timeout landing in the same cycle
        if (bus.dbg_ack_i) begin
          if (!we_q) rdata_d = bus.dbg_rdata_i;
          cnt_d   = 3'd0;
          state_d = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: begin
        if (tx_hs) begin
          if (we_q || cnt_q == 3'd4) begin
            cnt_d   = 3'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_ERR: begin
        if (tx_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.rx_valid_i && (state_q == S_REQ || state_q == S_RESP || state_q == S_ERR))
      ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.tx_valid_o  = tx_valid;
  assign bus.tx_data_o   = tx_data;
  assign bus.dbg_req_o   = (state_q == S_REQ);
  assign bus.dbg_we_o    = we_q;
  assign bus.dbg_addr_o  = addr_q;
  assign bus.dbg_wdata_o = wdata_q;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.overrun_o   = ovr_q;

endmodule

// File: tb/tb_dbg_cmd_master.sv
// Directed frame table for dbg_cmd_master plus hand sequences for reset-state checks,
// reset mid-WDATA and dbg_ack_i outside REQ. Inputs change and outputs are sampled on the falling edge.
module tb_dbg_cmd_master;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rstn_i;
  always #5 clk = ~clk;

  dbg_cmd_master_if bus();

  dbg_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk    (clk),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  typedef struct {
    logic [0:8][7:0] rx;
    int              n_rx;
    int              ack_dly;   // REQ cycles before the ack cycle; -1 = never ack
    logic [31:0]     rdata;
    int              exp_req;
    logic            exp_we;
    logic [31:0]     exp_addr;
    logic [31:0]     exp_wdata;
    logic [0:4][7:0] exp_tx;
    int              n_tx;
    int              stall;     // tx_ready_i low for this many tx_valid cycles
    bit              inject;    // push an rx byte during the stall
    logic            exp_ovr;
  } vec_t;

  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " tx_valid"},  {31'd0, bus.tx_valid_o}, 32'd0);
    chk({tag, " tx_data"},   {24'd0, bus.tx_data_o},  32'd0);
    chk({tag, " dbg_req"},   {31'd0, bus.dbg_req_o},  32'd0);
    chk({tag, " dbg_we"},    {31'd0, bus.dbg_we_o},   32'd0);
    chk({tag, " dbg_addr"},  bus.dbg_addr_o,          32'd0);
    chk({tag, " dbg_wdata"}, bus.dbg_wdata_o,         32'd0);
    chk({tag, " busy"},      {31'd0, bus.busy_o},     32'd0);
    chk({tag, " overrun"},   {31'd0, bus.overrun_o},  32'd0);
  endtask

  task automatic send_bytes(input logic [0:8][7:0] rx, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = rx[i];
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int          req_cnt    = 0;
    int          req_glitch = 0;
    int          stall_left = v.stall;
    int          unstable   = 0;
    bit          held_set   = 1'b0;
    bit          done       = 1'b0;
    logic [7:0]  held       = 8'h00;
    logic        got_we     = 1'b0;
    logic [31:0] got_addr   = 32'd0;
    logic [31:0] got_wdata  = 32'd0;
    logic [7:0]  txq[$];
    bus.dbg_rdata_i = v.rdata;
    bus.tx_ready_i  = 1'b1;
    send_bytes(v.rx, v.n_rx);
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) @(negedge clk);
      bus.rx_valid_i = 1'b0;
      bus.dbg_ack_i  = 1'b0;
      if (!bus.busy_o) begin
        done = 1'b1;
      end else begin
        if (bus.dbg_req_o) begin
          if (req_cnt == 0) begin
            got_we    = bus.dbg_we_o;
            got_addr  = bus.dbg_addr_o;
            got_wdata = bus.dbg_wdata_o;
          end else if (bus.dbg_we_o !== got_we || bus.dbg_addr_o !== got_addr ||
                       bus.dbg_wdata_o !== got_wdata) begin
            req_glitch++;
          end
          if (req_cnt == v.ack_dly) bus.dbg_ack_i = 1'b1;
          req_cnt++;
        end
        bus.tx_ready_i = 1'b1;
        if (bus.tx_valid_o) begin
          if (stall_left > 0) begin
            bus.tx_ready_i = 1'b0;
            if (!held_set) begin
              held     = bus.tx_data_o;
              held_set = 1'b1;
            end else if (bus.tx_data_o !== held) begin
              unstable++;
            end
            if (stall_left == 3 && v.inject) begin
              bus.rx_valid_i = 1'b1;
              bus.rx_data_i  = 8'h55;
            end
            stall_left--;
          end else begin
            txq.push_back(bus.tx_data_o);
          end
        end
      end
    end
    bus.dbg_ack_i  = 1'b0;
    bus.tx_ready_i = 1'b1;
    chk({tag, " frame_done"}, {31'd0, done}, 32'd1);
    chk({tag, " req_cycles"}, req_cnt, v.exp_req);
    if (v.exp_req > 0) begin
      chk({tag, " req_we"},     {31'd0, got_we}, {31'd0, v.exp_we});
      chk({tag, " req_addr"},   got_addr, v.exp_addr);
      chk({tag, " req_stable"}, req_glitch, 32'd0);
      if (v.exp_we) chk({tag, " req_wdata"}, got_wdata, v.exp_wdata);
    end
    chk({tag, " tx_count"}, txq.size(), v.n_tx);
    for (int i = 0; i < v.n_tx; i++)
      chk($sformatf("%s tx[%0d]", tag, i), (i < txq.size()) ? {24'd0, txq[i]} : 32'hFFFF_FFFF,
          {24'd0, v.exp_tx[i]});
    if (v.stall > 0) chk({tag, " tx_hold_stable"}, unstable, 32'd0);
    chk({tag, " overrun"},  {31'd0, bus.overrun_o},  {31'd0, v.exp_ovr});
    chk({tag, " idle_txv"}, {31'd0, bus.tx_valid_o}, 32'd0);
  endtask

  initial begin
    int idle_bad;

    vecs[0] = '{rx: {8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 32'd0}, n_rx: 5, ack_dly: 3,
                rdata: 32'hDEADBEEF, exp_req: 4, exp_we: 1'b0, exp_addr: 32'h10, exp_wdata: 32'd0,
                exp_tx: {8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, n_tx: 5, stall: 0, inject: 1'b0, exp_ovr: 1'b0};
    vecs[1] = '{rx: {8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, n_rx: 9, ack_dly: 0,
                rdata: 32'h0BAD0BAD, exp_req: 1, exp_we: 1'b1, exp_addr: 32'h4, exp_wdata: 32'h12345678,
                exp_tx: {8'hA5, 32'd0}, n_tx: 1, stall: 0, inject: 1'b0, exp_ovr: 1'b0};
    vecs[2] = '{rx: {8'h7F, 64'd0}, n_rx: 1, ack_dly: 0,
                rdata: 32'd0, exp_req: 0, exp_we: 1'b0, exp_addr: 32'd0, exp_wdata: 32'd0,
                exp_tx: {8'hEE, 32'd0}, n_tx: 1, stall: 0, inject: 1'b0, exp_ovr: 1'b0};
    vecs[3] = '{rx: {8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 32'd0}, n_rx: 5, ack_dly: -1,
                rdata: 32'h12121212, exp_req: TMO, exp_we: 1'b0, exp_addr: 32'h20, exp_wdata: 32'd0,
                exp_tx: {8'hEE, 32'd0}, n_tx: 1, stall: 0, inject: 1'b0, exp_ovr: 1'b0};
    vecs[4] = '{rx: {8'h01, 8'h04, 8'h00, 8'h00, 8'h80, 32'd0}, n_rx: 5, ack_dly: 1,
                rdata: 32'h01020304, exp_req: 2, exp_we: 1'b0, exp_addr: 32'h80000004, exp_wdata: 32'd0,
                exp_tx: {8'hA5, 8'h04, 8'h03, 8'h02, 8'h01}, n_tx: 5, stall: 0, inject: 1'b0, exp_ovr: 1'b0};
    vecs[5] = '{rx: {8'h01, 8'h0C, 8'h00, 8'h00, 8'h00, 32'd0}, n_rx: 5, ack_dly: 0,
                rdata: 32'hCAFEF00D, exp_req: 1, exp_we: 1'b0, exp_addr: 32'h0C, exp_wdata: 32'd0,
                exp_tx: {8'hA5, 8'h0D, 8'hF0, 8'hFE, 8'hCA}, n_tx: 5, stall: 5, inject: 1'b1, exp_ovr: 1'b1};
    vecs[6] = '{rx: {8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 32'd0}, n_rx: 5, ack_dly: 2,
                rdata: 32'h11223344, exp_req: 3, exp_we: 1'b0, exp_addr: 32'h08, exp_wdata: 32'd0,
                exp_tx: {8'hA5, 8'h44, 8'h33, 8'h22, 8'h11}, n_tx: 5, stall: 0, inject: 1'b0, exp_ovr: 1'b0};

    rstn_i          = 1'b0;
    bus.rx_data_i   = 8'h00;
    bus.rx_valid_i  = 1'b0;
    bus.tx_ready_i  = 1'b1;
    bus.dbg_ack_i   = 1'b0;
    bus.dbg_rdata_i = 32'd0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rstn_i = 1'b1;

    // a stray ack while idle must not start anything
    @(negedge clk);
    bus.dbg_ack_i = 1'b1;
    @(negedge clk);
    bus.dbg_ack_i = 1'b0;
    chk("idle_ack busy", {31'd0, bus.busy_o}, 32'd0);
    chk("idle_ack tx_valid", {31'd0, bus.tx_valid_o}, 32'd0);

    for (int k = 0; k < 6; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

    // reset in the middle of WDATA, then a clean read frame
    send_bytes({8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 16'd0}, 7);
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rstn_i = 1'b1;
    idle_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.busy_o || bus.tx_valid_o || bus.dbg_req_o) idle_bad++;
    end
    chk("post_rst quiet", idle_bad, 32'd0);
    run_frame(vecs[6], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_master.md
DBG_CMD_MASTER -- requirements
Module: dbg_cmd_master

Parameters
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles to wait for dbg_ack_i before aborting a request.

Interface
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_data_i  input  8  command byte from the host byte link.
REQ-005 SHALL have port rx_valid_i  input  1  rx_data_i valid for one cycle; no backpressure.
REQ-006 SHALL have port tx_data_o  output  8  response byte to the host byte link.
REQ-007 SHALL have port tx_valid_o  output  1  tx_data_o valid; held until tx_ready_i.
REQ-008 SHALL have port tx_ready_i  input  1  host link accepts tx_data_o this cycle.
REQ-009 SHALL have port dbg_req_o  output  1  request to the core debug module.
REQ-010 SHALL have port dbg_we_o  output  1  1 = write, 0 = read.
REQ-011 SHALL have port dbg_addr_o  output  32  target address or register index.
REQ-012 SHALL have port dbg_wdata_o  output  32  write data.
REQ-013 SHALL have port dbg_ack_i  input  1  debug module completes the request; single-cycle pulse.
REQ-014 SHALL have port dbg_rdata_i  input  32  read data, valid in the cycle dbg_ack_i=1.
REQ-015 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-016 SHALL have port overrun_o  output  1  sticky flag: an rx byte was dropped.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, WDATA, REQ, RESP, ERR.
REQ-018 SHALL, in IDLE, latch an rx byte as the command: 0x01 = read goes to ADDR with we=0; 0x02 = write goes to ADDR with we=1; any other value goes to ERR.
REQ-019 SHALL, in ADDR, collect 4 rx bytes LSB-first into dbg_addr_o, then go to WDATA if we=1, else to REQ.
REQ-020 SHALL, in WDATA, collect 4 rx bytes LSB-first into dbg_wdata_o, then go to REQ.
REQ-021 SHALL assert dbg_req_o in every REQ cycle, with addr, wdata and we stable, until dbg_ack_i or timeout.
REQ-022 SHALL accept dbg_ack_i in the first REQ cycle, so the minimum request length is 1 cycle.
REQ-023 SHALL, on dbg_ack_i in REQ, deassert dbg_req_o in the next cycle, capture dbg_rdata_i if we=0, and go to RESP.
REQ-024 SHALL count REQ cycles; after TIMEOUT_CYCLES cycles without ack, deassert dbg_req_o and go to ERR.
REQ-025 SHALL, in RESP, send status byte 0xA5, then for reads 4 rdata bytes LSB-first; each byte advances only on tx_valid_o && tx_ready_i.
REQ-026 SHALL, in ERR, send the single byte 0xEE.
REQ-027 SHALL return to IDLE after the last response byte of RESP or ERR is accepted.
REQ-028 SHALL keep tx_valid_o and tx_data_o stable while tx_ready_i=0.
REQ-029 SHALL ignore and drop rx bytes arriving in REQ, RESP or ERR, and set overrun_o.
REQ-030 SHALL clear overrun_o only by reset.
REQ-031 SHALL ignore dbg_ack_i outside REQ.
REQ-032 SHALL not time out in ADDR or WDATA; a partial frame waits indefinitely.

Reset
REQ-033 SHALL, while rstn_i=0, hold the FSM in IDLE and force dbg_req_o, dbg_we_o, tx_valid_o, busy_o and overrun_o to 0, dbg_addr_o, dbg_wdata_o and the rdata capture to 0, tx_data_o to 0x00, and the byte and timeout counters to 0.
REQ-034 SHALL, when reset asserts mid-frame or mid-request, abort immediately and emit no response after release.

Verification
REQ-035 SHALL be shown: rx 01,10,00,00,00 with ack 3 cycles later and rdata=0xDEADBEEF -> one dbg_req_o burst with addr=0x00000010 and we=0 -> tx A5,EF,BE,AD,DE.
REQ-036 SHALL be shown: rx 02,04,00,00,00,78,56,34,12 with ack in the 1st REQ cycle -> dbg_req_o 1 cycle wide, we=1, addr=0x4, wdata=0x12345678 -> tx A5.
REQ-037 SHALL be shown: rx 0x7F -> tx EE, with no dbg_req_o.
REQ-038 SHALL be shown: read with no ack and TIMEOUT_CYCLES=8 -> dbg_req_o high exactly 8 cycles -> tx EE -> busy_o=0.
REQ-039 SHALL be shown: tx_ready_i held low 5 cycles during RESP -> tx_data_o stable throughout; an rx byte arriving meanwhile -> overrun_o=1 and the response is unchanged.
REQ-040 SHALL be shown: rstn_i pulsed low during WDATA -> all outputs at reset values -> a new read frame then completes normally.
